dmem_bridge: RTL and testbench

- Data-side bus bridge between the mips core's ram_* port and the dataMem distributed RAM (word-wide, single write enable, asynchronous read).
- Converts byte-lane stores (sel) into registered read-modify-write cycles, stalling the core while it does so.
- Decodes a small memory-mapped IO window holding a beep control register and a free-running cycle counter.
- Instantiated in mips_sopc in place of the direct core-to-dataMem wiring.

---
 rtl/dmem_bridge_pkg.sv | 30 +++
 rtl/dmem_bridge_if.sv | 33 +++
 rtl/dmem_io_regs.sv | 42 ++++
 rtl/dmem_bridge.sv | 91 +++++++++
 tb/tb_dmem_bridge.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-side bus bridge.
// Holds the bridge FSM encoding, the IO register offsets and the byte-lane merge helper.
package dmem_bridge_pkg;

  typedef enum logic [0:0] {
    DmIdle,
    DmMerge
  } dm_state_e;

  localparam logic [1:0] IoBeepOff = 2'd0;
  localparam logic [1:0] IoCntOff  = 2'd1;

  localparam logic [3:0] SelNone = 4'h0;
  localparam logic [3:0] SelFull = 4'hF;

  // Lanes with sel set take the new word, the rest keep the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] new_word,
                                             input logic [31:0] old_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side data bus between the mips core and the data memory bridge.
// The core drives the request and must hold it stable while stall_o is high.
interface dmem_bridge_if;

  logic        ce_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;

  modport master (
    output ce_i,
    output we_i,
    output sel_i,
    output addr_i,
    output data_i,
    input  data_o,
    input  stall_o
  );

  modport slave (
    input  ce_i,
    input  we_i,
    input  sel_i,
    input  addr_i,
    input  data_i,
    output data_o,
    output stall_o
  );

endinterface

// File: rtl/dmem_io_regs.sv
// Memory-mapped IO registers of the data bridge: beep control bit and a free-running
// cycle counter, plus the combinational IO read mux.
module dmem_io_regs
  import dmem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [1:0]  off_i,
  input  logic        sel0_i,
  input  logic        wdata0_i,
  output logic [31:0] rdata_o,
  output logic        beep_o
);

  logic        beep_ctrl_q;
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      beep_ctrl_q <= 1'b0;
      cyc_cnt_q   <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (wr_en_i && (off_i == IoBeepOff) && sel0_i) begin
        beep_ctrl_q <= wdata0_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      IoBeepOff: rdata_o = {31'b0, beep_ctrl_q};
      IoCntOff:  rdata_o = cyc_cnt_q;
      default:   rdata_o = '0;
    endcase
  end

  assign beep_o = beep_ctrl_q;

endmodule

// File: rtl/dmem_bridge.sv
// Data-side bridge from the mips core to the dataMem distributed RAM. Partial stores become a
// two-cycle read-modify-write; the top address nibble IO_BASE selects the IO register window.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned RAM_AW  = 11,
  parameter logic [3:0]  IO_BASE = 4'h8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_bridge_if.slave      bus,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [31:0]       ram_d_o,
  input  logic [31:0]       ram_spo_i,
  output logic              io_beep_o
);

  dm_state_e   state_q;
  logic [31:0] merge_q;

  logic        io_hit;
  logic        ram_hit;
  logic        full_store;
  logic        part_store;
  logic [31:0] io_rdata;

  assign io_hit     = bus.ce_i & (bus.addr_i[31:28] == IO_BASE);
  assign ram_hit    = bus.ce_i & ~io_hit;
  assign full_store = ram_hit & bus.we_i & (bus.sel_i == SelFull);
  assign part_store = ram_hit & bus.we_i & (bus.sel_i != SelFull) & (bus.sel_i != SelNone);

  assign ram_a_o = bus.addr_i[RAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DmIdle;
      merge_q <= '0;
    end else begin
      case (state_q)
        DmIdle: begin
          if (part_store) begin
            merge_q <= lane_merge(bus.data_i, ram_spo_i, bus.sel_i);
            state_q <= DmMerge;
          end
        end
        DmMerge: state_q <= DmIdle;
        default: state_q <= DmIdle;
      endcase
    end
  end

  // Write strobes are gated by rst so a store pending under reset never reaches the RAM.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_d_o     = bus.data_i;
    bus.stall_o = 1'b0;
    if (state_q == DmMerge) begin
      ram_we_o = rst;
      ram_d_o  = merge_q;
    end else if (full_store) begin
      ram_we_o = rst;
    end else if (part_store) begin
      bus.stall_o = rst;
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (io_hit) begin
      bus.data_o = io_rdata;
    end else if (ram_hit) begin
      bus.data_o = ram_spo_i;
    end
  end

  dmem_io_regs u_io (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (io_hit & bus.we_i),
    .off_i    (bus.addr_i[3:2]),
    .sel0_i   (bus.sel_i[0]),
    .wdata0_i (bus.data_i[0]),
    .rdata_o  (io_rdata),
    .beep_o   (io_beep_o)
  );

  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a word-array reference model.
module tb_dmem_bridge;

  localparam int unsigned RamAw = 11;
  localparam int unsigned Words = 2 ** RamAw;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_bridge_if bus ();

  logic             ram_we;
  logic [RamAw-1:0] ram_a;
  logic [31:0]      ram_d;
  logic [31:0]      ram_spo;
  logic             io_beep;

  dmem_bridge #(
    .RAM_AW  (RamAw),
    .IO_BASE (4'h8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_we_o  (ram_we),
    .ram_a_o   (ram_a),
    .ram_d_o   (ram_d),
    .ram_spo_i (ram_spo),
    .io_beep_o (io_beep)
  );

  // dataMem stand-in: asynchronous read, synchronous write
  logic [31:0] env_mem [Words];
  assign ram_spo = env_mem[ram_a];
  always @(posedge clk) if (ram_we) env_mem[ram_a] <= ram_d;

  // Reference model: architectural memory contents, beep bit and cycles since reset
  logic [31:0] ref_mem [Words];
  logic        ref_beep;
  int unsigned ref_cyc;
  always @(posedge clk) begin
    if (!rst) ref_cyc <= 0;
    else      ref_cyc <= ref_cyc + 1;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ce, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.ce_i   = ce;
    bus.we_i   = we;
    bus.sel_i  = sel;
    bus.addr_i = addr;
    bus.data_i = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[RamAw+1:2]);
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[31:28] == 4'h8;
  endfunction

  function automatic logic [31:0] byte_store(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] sel);
    if (is_io(addr)) begin
      if (addr[3:2] == 2'd0 && sel[0]) ref_beep = data[0];
    end else if (sel != 4'h0) begin
      ref_mem[widx(addr)] = byte_store(ref_mem[widx(addr)], data, sel);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (!is_io(addr)) return ref_mem[widx(addr)];
    case (addr[3:2])
      2'd0:    return {31'b0, ref_beep};
      2'd1:    return ref_cyc;
      default: return 32'h0;
    endcase
  endfunction

  // One core access, including the MERGE cycle of a partial store
  task automatic access(input string nm, input logic ce, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] data);
    logic part, full;
    part = ce && we && !is_io(addr) && sel != 4'h0 && sel != 4'hF;
    full = ce && we && !is_io(addr) && sel == 4'hF;
    drive(ce, we, sel, addr, data);
    #3;
    if (!ce) check({nm, " idle data_o"}, bus.data_o, 32'h0);
    else if (!we) check({nm, " load data_o"}, bus.data_o, model_read(addr));
    check({nm, " stall"}, {31'b0, bus.stall_o}, {31'b0, part});
    check({nm, " ram_we"}, {31'b0, ram_we}, {31'b0, full});
    check({nm, " ram_a"}, {21'b0, ram_a}, widx(addr));
    check({nm, " beep"}, {31'b0, io_beep}, {31'b0, ref_beep});
    if (full) check({nm, " ram_d"}, ram_d, data);
    tick();
    if (part) begin
      #3;
      check({nm, " merge stall"}, {31'b0, bus.stall_o}, 32'h0);
      check({nm, " merge we"}, {31'b0, ram_we}, 32'h1);
      check({nm, " merge ram_d"}, ram_d, byte_store(ref_mem[widx(addr)], data, sel));
      tick();
    end
    if (ce && we) model_store(addr, data, sel);
  endtask

  typedef struct {
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_do;
    logic [31:0] exp_do;
    logic        exp_we;
    logic        exp_beep;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, v, addr;
    logic [3:0]  sel;
    int          kind;

    for (int i = 0; i < int'(Words); i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    ref_beep = 1'b0;

    rst = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    repeat (3) tick();
    #3;
    check("reset stall", {31'b0, bus.stall_o}, 32'h0);
    check("reset ram_we", {31'b0, ram_we}, 32'h0);
    check("reset beep", {31'b0, io_beep}, 32'h0);
    check("reset cyc_cnt", bus.data_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //        ce    we    sel    addr          data          chk   exp_do        we    beep
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'hF, 32'h8000_0008, 32'h0,         1'b1, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 32'h8000_000C, 32'h0,         1'b1, 32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h8000_0004, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h5555_5555, 1'b1, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 4'hE, 32'h8000_0000, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'h1, 32'h8000_0000, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0,         1'b1, 32'h0,        1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ce, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data);
      #3;
      if (vecs[i].chk_do) check($sformatf("vec%0d data_o", i), bus.data_o, vecs[i].exp_do);
      check($sformatf("vec%0d stall", i), {31'b0, bus.stall_o}, 32'h0);
      check($sformatf("vec%0d ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].exp_we});
      check($sformatf("vec%0d beep", i), {31'b0, io_beep}, {31'b0, vecs[i].exp_beep});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d ram_a", i), {21'b0, ram_a}, 32'h4);
        check($sformatf("vec%0d ram_d", i), ram_d, vecs[i].data);
      end
      tick();
      if (vecs[i].ce && vecs[i].we) model_store(vecs[i].addr, vecs[i].data, vecs[i].sel);
    end

    // Partial store into a known word
    access("seed", 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    drive(1'b1, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AA00);
    #3;
    check("part stall1", {31'b0, bus.stall_o}, 32'h1);
    check("part we1", {31'b0, ram_we}, 32'h0);
    tick();
    #3;
    check("part stall2", {31'b0, bus.stall_o}, 32'h0);
    check("part we2", {31'b0, ram_we}, 32'h1);
    check("part ram_d", ram_d, 32'h1122_AA44);
    tick();
    model_store(32'h0000_0010, 32'h0000_AA00, 4'b0010);
    drive(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #3;
    check("part reload", bus.data_o, 32'h1122_AA44);
    tick();

    // Back-to-back partial stores, the second touching the same word
    access("b2b0", 1'b1, 1'b1, 4'b1000, 32'h0000_0010, 32'h7700_0000);
    access("b2b1", 1'b1, 1'b1, 4'b0001, 32'h0000_0010, 32'h0000_0066);
    access("b2b ld", 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);

    // Cycle counter advances by the number of elapsed edges
    drive(1'b1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    #3;
    a = bus.data_o;
    repeat (7) @(posedge clk);
    #3;
    b = bus.data_o;
    check("cnt delta", b - a, 32'd7);
    tick();

    // Reset in the MERGE cycle drops the pending write
    access("beep on", 1'b1, 1'b1, 4'hF, 32'h8000_0000, 32'h1);
    drive(1'b1, 1'b1, 4'b0001, 32'h0000_0020, 32'h0000_00FF);
    #3;
    check("rstm stall", {31'b0, bus.stall_o}, 32'h1);
    tick();
    rst = 1'b0;
    #3;
    check("rstm we", {31'b0, ram_we}, 32'h0);
    check("rstm stall0", {31'b0, bus.stall_o}, 32'h0);
    tick();
    rst = 1'b1;
    ref_beep = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    #3;
    check("rstm word", env_mem[8], ref_mem[8]);
    check("rstm beep", {31'b0, io_beep}, 32'h0);
    check("rstm cnt", bus.data_o, 32'h0);
    check("rstm stall1", {31'b0, bus.stall_o}, 32'h0);
    tick();
    access("rstm ld", 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);

    // Randomized accesses against the reference model
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 7);
      addr = $urandom;
      addr[1:0] = 2'b00;
      addr[RamAw+1:2] = RamAw'($urandom_range(0, 15));
      if (addr[31:28] == 4'h8) addr[31:28] = 4'h0;
      sel = 4'(($urandom_range(1, 14)));
      case (kind)
        0, 1: access("rnd ld", 1'b1, 1'b0, 4'(($urandom)), addr, $urandom);
        2:    access("rnd sw", 1'b1, 1'b1, 4'hF, addr, $urandom);
        3, 4: access("rnd part", 1'b1, 1'b1, sel, addr, $urandom);
        5:    access("rnd sel0", 1'b1, 1'b1, 4'h0, addr, $urandom);
        6: begin
          addr[31:28] = 4'h8;
          addr[3:2]   = 2'($urandom_range(0, 3));
          access("rnd io", 1'b1, 1'($urandom), 4'(($urandom)), addr, $urandom);
        end
        default: access("rnd ce0", 1'b0, 1'($urandom), 4'(($urandom)), addr, $urandom);
      endcase
    end

    // Counter wrap
    drive(1'b1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    #1;
    force dut.u_io.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    check("wrap max", bus.data_o, 32'hFFFF_FFFF);
    release dut.u_io.cyc_cnt_q;
    @(posedge clk);
    #3;
    check("wrap zero", bus.data_o, 32'h0);
    @(posedge clk);
    #3;
    check("wrap one", bus.data_o, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
